sdspi_perf_meter: RTL

- Measures one UUT run: counts clk cycles from the sdspi_start rising edge to the sdspi_finish rising edge, with a timeout.
- Packs the result and the run parameters into a fixed 12-byte record.
- Streams the record out byte by byte over a valid/ready handshake. The autotest FSM consumes these bytes and writes them to the SD card via the sdspihost byte-write path.
- Sits beside fsm_autotest, downstream of the UUT result signals.

---
 rtl/sdspi_perf_pkg.sv | 22 ++
 rtl/perf_record_mux.sv | 56 +++++
 rtl/sdspi_perf_meter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/sdspi_perf_pkg.sv
// Shared types and record layout constants for the SD-SPI performance meter.
package sdspi_perf_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_START = 3'd1,
    MEASURE    = 3'd2,
    EMIT       = 3'd3,
    DONE       = 3'd4
  } perf_state_e;

  localparam int unsigned REC_LEN    = 12;
  localparam int unsigned IDX_W      = 4;
  localparam logic [7:0]  REC_MAGIC0 = 8'hA5;
  localparam logic [7:0]  REC_MAGIC1 = 8'h5A;

  localparam int unsigned OFS_FLAGS  = 2;
  localparam int unsigned OFS_NBLK   = 3;
  localparam int unsigned OFS_CYC    = 7;
  localparam int unsigned OFS_CSUM   = 11;

endpackage

// File: rtl/perf_record_mux.sv
// Selects one byte of the 12-byte result record and keeps a running XOR checksum
// of the bytes already accepted, so the checksum byte needs no wide XOR tree.
module perf_record_mux
  import sdspi_perf_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             accept,
  input  logic [7:0]       cur_byte,
  input  logic [IDX_W-1:0] sel,
  input  logic             cmd18,
  input  logic             timeout,
  input  logic [4:0]       sclk_speed,
  input  logic [31:0]      n_blocks,
  input  logic [31:0]      cycles32,
  output logic [7:0]       rec_byte_c
);

  logic [7:0] acc_q;
  logic [7:0] acc_nxt_c;

  assign acc_nxt_c = acc_q ^ cur_byte;

  // Checksum accumulates each byte as the consumer takes it
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q <= 8'h00;
    end else if (clear) begin
      acc_q <= 8'h00;
    end else if (accept) begin
      acc_q <= acc_nxt_c;
    end
  end

  // sel==OFS_CSUM is only requested while byte 10 is being accepted, so fold it in
  always_comb begin
    rec_byte_c = 8'h00;
    case (sel)
      IDX_W'(0):            rec_byte_c = REC_MAGIC0;
      IDX_W'(1):            rec_byte_c = REC_MAGIC1;
      IDX_W'(OFS_FLAGS):    rec_byte_c = {cmd18, timeout, sclk_speed, 1'b0};
      IDX_W'(OFS_NBLK):     rec_byte_c = n_blocks[31:24];
      IDX_W'(OFS_NBLK + 1): rec_byte_c = n_blocks[23:16];
      IDX_W'(OFS_NBLK + 2): rec_byte_c = n_blocks[15:8];
      IDX_W'(OFS_NBLK + 3): rec_byte_c = n_blocks[7:0];
      IDX_W'(OFS_CYC):      rec_byte_c = cycles32[31:24];
      IDX_W'(OFS_CYC + 1):  rec_byte_c = cycles32[23:16];
      IDX_W'(OFS_CYC + 2):  rec_byte_c = cycles32[15:8];
      IDX_W'(OFS_CYC + 3):  rec_byte_c = cycles32[7:0];
      IDX_W'(OFS_CSUM):     rec_byte_c = acc_nxt_c;
      default:              rec_byte_c = 8'h00;
    endcase
  end

endmodule

// File: rtl/sdspi_perf_meter.sv
// Times one UUT run (start rise to finish rise, with timeout) and streams a
// 12-byte result record over a valid/ready byte interface.
module sdspi_perf_meter
  import sdspi_perf_pkg::*;
#(
  parameter int unsigned      CNT_W          = 32,
  parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = CNT_W'(32'd100_000_000)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic [31:0]      n_blocks,
  input  logic [4:0]       sclk_speed,
  input  logic             cmd18,
  input  logic             sdspi_start,
  input  logic             sdspi_finish,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycles,
  output logic             byte_valid,
  output logic [7:0]       byte_data,
  output logic             byte_last,
  input  logic             byte_ready
);

  perf_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_c;
  logic [CNT_W-1:0] cycles_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      nblk_q, nblk_d;
  logic [4:0]       speed_q, speed_d;
  logic             cmd18_q, cmd18_d;
  logic             start_q, finish_q;
  logic             start_re_c, finish_re_c;
  logic             busy_d, done_d, timeout_d;
  logic             valid_d, last_d;
  logic [7:0]       data_d;
  logic             acc_clear_c, accept_c;
  logic [7:0]       rec_byte_c;

  assign start_re_c  = sdspi_start  & ~start_q;
  assign finish_re_c = sdspi_finish & ~finish_q;
  assign cnt_inc_c   = cnt_q + CNT_W'(1);

  perf_record_mux u_rec_mux (
    .clk        (clk),
    .rst        (rst),
    .clear      (acc_clear_c),
    .accept     (accept_c),
    .cur_byte   (byte_data),
    .sel        (idx_q + IDX_W'(1)),
    .cmd18      (cmd18_q),
    .timeout    (timeout),
    .sclk_speed (speed_q),
    .n_blocks   (nblk_q),
    .cycles32   (32'(cycles)),
    .rec_byte_c (rec_byte_c)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cycles     <= '0;
      idx_q      <= '0;
      nblk_q     <= '0;
      speed_q    <= '0;
      cmd18_q    <= 1'b0;
      start_q    <= 1'b0;
      finish_q   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      byte_valid <= 1'b0;
      byte_data  <= 8'h00;
      byte_last  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cycles     <= cycles_d;
      idx_q      <= idx_d;
      nblk_q     <= nblk_d;
      speed_q    <= speed_d;
      cmd18_q    <= cmd18_d;
      start_q    <= sdspi_start;
      finish_q   <= sdspi_finish;
      busy       <= busy_d;
      done       <= done_d;
      timeout    <= timeout_d;
      byte_valid <= valid_d;
      byte_data  <= data_d;
      byte_last  <= last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cycles_d    = cycles;
    idx_d       = idx_q;
    nblk_d      = nblk_q;
    speed_d     = speed_q;
    cmd18_d     = cmd18_q;
    timeout_d   = timeout;
    valid_d     = byte_valid;
    data_d      = byte_data;
    last_d      = byte_last;
    acc_clear_c = 1'b0;
    accept_c    = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (arm) begin
          nblk_d    = n_blocks;
          speed_d   = sclk_speed;
          cmd18_d   = cmd18;
          cnt_d     = '0;
          timeout_d = 1'b0;
          state_d   = WAIT_START;
        end
      end
      WAIT_START, MEASURE: begin
        // Timeout and finish both land in EMIT; finish has priority over timeout
        if (state_q == WAIT_START && start_re_c) begin
          cnt_d   = '0;
          state_d = MEASURE;
        end else if (state_q == MEASURE && finish_re_c) begin
          cycles_d = cnt_inc_c;
          state_d  = EMIT;
        end else if (cnt_inc_c == TIMEOUT_CYCLES) begin
          timeout_d = 1'b1;
          cycles_d  = TIMEOUT_CYCLES;
          state_d   = EMIT;
        end else begin
          cnt_d = cnt_inc_c;
        end
        if (state_d == EMIT) begin
          valid_d     = 1'b1;
          data_d      = REC_MAGIC0;
          last_d      = 1'b0;
          idx_d       = '0;
          acc_clear_c = 1'b1;
        end
      end
      EMIT: begin
        if (byte_ready) begin
          accept_c = 1'b1;
          if (idx_q == IDX_W'(REC_LEN - 1)) begin
            valid_d = 1'b0;
            data_d  = 8'h00;
            last_d  = 1'b0;
            idx_d   = '0;
            state_d = DONE;
          end else begin
            idx_d  = idx_q + IDX_W'(1);
            data_d = rec_byte_c;
            last_d = (idx_q == IDX_W'(REC_LEN - 2));
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == WAIT_START) || (state_d == MEASURE) || (state_d == EMIT);
    done_d = (state_d == DONE);
  end

endmodule
